// File: rtl/pwm_pkg.sv
// Shared types and constants for the time-multiplexed PWM bank.
package pwm_pkg;

  typedef enum logic [1:0] {
    REG_RISE   = 2'd0,
    REG_FALL   = 2'd1,
    REG_CTRL   = 2'd2,
    REG_PERIOD = 2'd3
  } wr_reg_e;

  localparam int unsigned CTRL_EN  = 0;
  localparam int unsigned CTRL_INV = 1;

  // Channel-select width; a single channel still needs one bit.
  function automatic int unsigned ch_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pwm_bank_if.sv
// Register-write bus of the PWM bank, plus the shadow-transfer lock.
interface pwm_bank_if #(
  parameter int unsigned PWM_WIDTH = 16,
  parameter int unsigned NUM_PWM   = 4
);
  import pwm_pkg::*;

  localparam int unsigned CH_W = ch_width(NUM_PWM);

  logic                 wr_en;
  logic [CH_W-1:0]      wr_ch;
  wr_reg_e              wr_reg;
  logic [PWM_WIDTH-1:0] wr_data;
  logic                 lock;

  modport master (output wr_en, wr_ch, wr_reg, wr_data, lock);
  modport slave  (input  wr_en, wr_ch, wr_reg, wr_data, lock);

endinterface

// File: rtl/pwm_shadow_bank.sv
// Shadow/active register pairs; shadows take bus writes, actives reload on xfer.
module pwm_shadow_bank
  import pwm_pkg::*;
#(
  parameter int unsigned PWM_WIDTH = 16,
  parameter int unsigned NUM_PWM   = 4
) (
  input  logic                                clk,
  input  logic                                rst_n,
  pwm_bank_if.slave                           bus,
  input  logic                                xfer,
  output logic [NUM_PWM-1:0][PWM_WIDTH-1:0]   rise,
  output logic [NUM_PWM-1:0][PWM_WIDTH-1:0]   fall,
  output logic [NUM_PWM-1:0]                  en,
  output logic [NUM_PWM-1:0]                  inv,
  output logic [PWM_WIDTH-1:0]                period,
  output logic [NUM_PWM-1:0]                  en_nxt_c,
  output logic [NUM_PWM-1:0]                  inv_nxt_c
);

  localparam int unsigned CH_W  = ch_width(NUM_PWM);
  localparam int unsigned CH_W1 = CH_W + 1;

  logic [NUM_PWM-1:0][PWM_WIDTH-1:0] rise_sh;
  logic [NUM_PWM-1:0][PWM_WIDTH-1:0] fall_sh;
  logic [NUM_PWM-1:0]                en_sh;
  logic [NUM_PWM-1:0]                inv_sh;
  logic [PWM_WIDTH-1:0]              period_sh;
  logic                              ch_ok_c;

  assign ch_ok_c   = ({1'b0, bus.wr_ch} < CH_W1'(NUM_PWM));
  assign en_nxt_c  = xfer ? en_sh  : en;
  assign inv_nxt_c = xfer ? inv_sh : inv;

  // Transfer samples the shadows before any same-cycle write lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rise_sh   <= '0;
      fall_sh   <= '0;
      en_sh     <= '0;
      inv_sh    <= '0;
      period_sh <= '1;
      rise      <= '0;
      fall      <= '0;
      en        <= '0;
      inv       <= '0;
      period    <= '1;
    end else begin
      if (bus.wr_en) begin
        case (bus.wr_reg)
          REG_RISE:   if (ch_ok_c) rise_sh[bus.wr_ch] <= bus.wr_data;
          REG_FALL:   if (ch_ok_c) fall_sh[bus.wr_ch] <= bus.wr_data;
          REG_CTRL: begin
            if (ch_ok_c) begin
              en_sh[bus.wr_ch]  <= bus.wr_data[CTRL_EN];
              inv_sh[bus.wr_ch] <= bus.wr_data[CTRL_INV];
            end
          end
          REG_PERIOD: period_sh <= bus.wr_data;
          default:    ;
        endcase
      end
      if (xfer) begin
        rise   <= rise_sh;
        fall   <= fall_sh;
        en     <= en_sh;
        inv    <= inv_sh;
        period <= period_sh;
      end
    end
  end

endmodule

// File: rtl/pwm_bank.sv
// Multi-channel PWM: one shared equality comparator pair visits a channel per clock.
module pwm_bank
  import pwm_pkg::*;
#(
  parameter int unsigned PWM_WIDTH = 16,
  parameter int unsigned NUM_PWM   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  pwm_bank_if.slave          bus,
  output logic [NUM_PWM-1:0] pwm_out,
  output logic               period_stb
);

  localparam int unsigned     CH_W      = ch_width(NUM_PWM);
  localparam logic [CH_W-1:0] LAST_SLOT = CH_W'(NUM_PWM - 1);

  logic [CH_W-1:0]                   slot;
  logic [PWM_WIDTH-1:0]              cnt;
  logic [NUM_PWM-1:0]                q;
  logic [NUM_PWM-1:0][PWM_WIDTH-1:0] rise;
  logic [NUM_PWM-1:0][PWM_WIDTH-1:0] fall;
  logic [NUM_PWM-1:0]                en;
  logic [NUM_PWM-1:0]                inv;
  logic [PWM_WIDTH-1:0]              period;
  logic [NUM_PWM-1:0]                en_nxt_c;
  logic [NUM_PWM-1:0]                inv_nxt_c;
  logic                              last_slot_c;
  logic                              wrap_c;
  logic                              xfer_c;
  logic                              hit_rise_c;
  logic                              hit_fall_c;
  logic [NUM_PWM-1:0]                q_nxt_c;

  pwm_shadow_bank #(
    .PWM_WIDTH (PWM_WIDTH),
    .NUM_PWM   (NUM_PWM)
  ) u_shadow (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .xfer      (xfer_c),
    .rise      (rise),
    .fall      (fall),
    .en        (en),
    .inv       (inv),
    .period    (period),
    .en_nxt_c  (en_nxt_c),
    .inv_nxt_c (inv_nxt_c)
  );

  // Slot-selected compare; fall wins over rise so rise==fall stays low.
  always_comb begin
    last_slot_c = (slot == LAST_SLOT);
    wrap_c      = last_slot_c && (cnt == period);
    xfer_c      = wrap_c && !bus.lock;
    hit_rise_c  = (cnt == rise[slot]);
    hit_fall_c  = (cnt == fall[slot]);
    q_nxt_c     = q;
    if (hit_fall_c) begin
      q_nxt_c[slot] = 1'b0;
    end else if (hit_rise_c) begin
      q_nxt_c[slot] = 1'b1;
    end
  end

  // Output flop is fed from next-state values so it tracks q/en/inv without lag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot       <= '0;
      cnt        <= '0;
      q          <= '0;
      period_stb <= 1'b0;
      pwm_out    <= '0;
    end else begin
      slot <= last_slot_c ? '0 : slot + CH_W'(1);
      if (last_slot_c) begin
        cnt <= (cnt == period) ? '0 : cnt + PWM_WIDTH'(1);
      end
      q          <= q_nxt_c;
      period_stb <= wrap_c;
      pwm_out    <= en_nxt_c & (q_nxt_c ^ inv_nxt_c);
    end
  end

endmodule

// File: tb/tb_pwm_bank.sv
// Directed bench for pwm_bank: a 4-channel and a 3-channel instance, 8-bit counters.
module tb_pwm_bank;
  import pwm_pkg::*;

  localparam int unsigned W = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] pwm_out4;
  logic       stb4;
  logic [2:0] pwm_out3;
  logic       stb3;

  int         total = 0;
  int         bad   = 0;
  int         hi [4];
  int         sidx;
  int         n;
  bit         found;
  logic [3:0] ats;

  always #5 clk = ~clk;

  pwm_bank_if #(.PWM_WIDTH(W), .NUM_PWM(4)) bus4 ();
  pwm_bank_if #(.PWM_WIDTH(W), .NUM_PWM(3)) bus3 ();

  pwm_bank #(.PWM_WIDTH(W), .NUM_PWM(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .bus(bus4), .pwm_out(pwm_out4), .period_stb(stb4)
  );
  pwm_bank #(.PWM_WIDTH(W), .NUM_PWM(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .bus(bus3), .pwm_out(pwm_out3), .period_stb(stb3)
  );

  task automatic check_eq(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One write cycle; called at a falling edge, returns at the next one.
  task automatic wr(input bit on3, input int ch, input wr_reg_e r, input int data);
    if (on3) begin
      bus3.wr_en = 1'b1; bus3.wr_ch = 2'(ch); bus3.wr_reg = r; bus3.wr_data = W'(data);
    end else begin
      bus4.wr_en = 1'b1; bus4.wr_ch = 2'(ch); bus4.wr_reg = r; bus4.wr_data = W'(data);
    end
    @(negedge clk);
    bus4.wr_en = 1'b0;
    bus3.wr_en = 1'b0;
  endtask

  task automatic wait_stb(input bit on3, input int budget, output int cnt, output bit seen);
    cnt  = 0;
    seen = 1'b0;
    while (!seen && cnt < budget) begin
      @(negedge clk);
      cnt++;
      seen = on3 ? stb3 : stb4;
    end
  endtask

  task automatic measure(input bit on3, input int len, output int h [4],
                         output int stb_idx, output logic [3:0] at_stb);
    logic [3:0] p;
    for (int c = 0; c < 4; c++) h[c] = 0;
    stb_idx = -1;
    at_stb  = '0;
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      p = on3 ? {1'b0, pwm_out3} : pwm_out4;
      for (int c = 0; c < 4; c++) if (p[c]) h[c]++;
      if ((on3 ? stb3 : stb4) && stb_idx < 0) begin
        stb_idx = i;
        at_stb  = p;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    bus4.wr_en = 1'b0; bus4.wr_ch = '0; bus4.wr_reg = REG_RISE; bus4.wr_data = '0; bus4.lock = 1'b0;
    bus3.wr_en = 1'b0; bus3.wr_ch = '0; bus3.wr_reg = REG_RISE; bus3.wr_data = '0; bus3.lock = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_pwm", int'(pwm_out4), 0);
    check_eq("rst_stb", int'(stb4), 0);
    rst_n = 1'b1;

    // Default PERIOD is all-ones: first wrap after 256*4 clocks.
    wait_stb(1'b0, 1100, n, found);
    check_eq("first_stb_clocks", n, 1024);
    check_eq("idle_out", int'(pwm_out4), 0);

    wr(1'b0, 0, REG_PERIOD, 9);
    wr(1'b0, 0, REG_RISE, 0); wr(1'b0, 0, REG_FALL, 3); wr(1'b0, 0, REG_CTRL, 1);
    wr(1'b0, 1, REG_RISE, 5); wr(1'b0, 1, REG_FALL, 2); wr(1'b0, 1, REG_CTRL, 1);
    wr(1'b0, 2, REG_RISE, 4); wr(1'b0, 2, REG_FALL, 4); wr(1'b0, 2, REG_CTRL, 1);
    wait_stb(1'b0, 1100, n, found);
    check_eq("cfg_wrap_seen", int'(found), 1);
    wait_stb(1'b0, 60, n, found);
    check_eq("stb_spacing", n, 40);
    measure(1'b0, 40, hi, sidx, ats);
    check_eq("duty_ch0", hi[0], 12);
    check_eq("duty_ch1_wrap", hi[1], 28);
    check_eq("degen_ch2", hi[2], 0);
    check_eq("off_ch3", hi[3], 0);
    check_eq("stb_idx", sidx, 39);
    check_eq("ch1_high_at_stb", int'(ats[1]), 1);

    // Inverting the degenerate channel takes effect only at the wrap.
    wr(1'b0, 2, REG_CTRL, 3);
    check_eq("inv_pending", int'(pwm_out4[2]), 0);
    wait_stb(1'b0, 60, n, found);
    check_eq("inv_wrap_cnt", n, 39);
    measure(1'b0, 40, hi, sidx, ats);
    check_eq("inv_ch2", hi[2], 40);

    bus4.lock = 1'b1;
    wr(1'b0, 0, REG_FALL, 7);
    wait_stb(1'b0, 60, n, found);
    check_eq("lock_wrap_seen", int'(found), 1);
    measure(1'b0, 40, hi, sidx, ats);
    check_eq("lock_duty_a", hi[0], 12);
    measure(1'b0, 40, hi, sidx, ats);
    check_eq("lock_duty_b", hi[0], 12);
    bus4.lock = 1'b0;
    wait_stb(1'b0, 60, n, found);
    check_eq("unlock_wrap_seen", int'(found), 1);
    measure(1'b0, 40, hi, sidx, ats);
    check_eq("unlock_duty", hi[0], 28);
    check_eq("unlock_stb_idx", sidx, 39);

    // Write presented on the very edge that wraps the counter.
    repeat (39) @(negedge clk);
    bus4.wr_en = 1'b1; bus4.wr_ch = 2'd0; bus4.wr_reg = REG_FALL; bus4.wr_data = W'(5);
    @(negedge clk);
    bus4.wr_en = 1'b0;
    check_eq("collide_on_wrap", int'(stb4), 1);
    measure(1'b0, 40, hi, sidx, ats);
    check_eq("collide_old", hi[0], 28);
    measure(1'b0, 40, hi, sidx, ats);
    check_eq("collide_new", hi[0], 20);

    // Three-channel instance: out-of-range channel writes are dropped.
    wr(1'b1, 0, REG_PERIOD, 9);
    wr(1'b1, 2, REG_RISE, 0); wr(1'b1, 2, REG_FALL, 3); wr(1'b1, 2, REG_CTRL, 1);
    wr(1'b1, 3, REG_RISE, 0); wr(1'b1, 3, REG_FALL, 6); wr(1'b1, 3, REG_CTRL, 1);
    wait_stb(1'b1, 800, n, found);
    check_eq("n3_wrap_a", int'(found), 1);
    wait_stb(1'b1, 800, n, found);
    check_eq("n3_wrap_b", int'(found), 1);
    measure(1'b1, 30, hi, sidx, ats);
    check_eq("n3_duty_ch2", hi[2], 9);
    check_eq("n3_ch0", hi[0], 0);
    check_eq("n3_ch1", hi[1], 0);
    check_eq("n3_stb_idx", sidx, 29);

    // Mid-run reset right after a wrap, while ch1 and ch2 are high.
    wait_stb(1'b0, 60, n, found);
    check_eq("pre_reset_out", int'(pwm_out4), 6);
    rst_n = 1'b0;
    #1;
    check_eq("midrst_pwm", int'(pwm_out4), 0);
    check_eq("midrst_stb", int'(stb4), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_stb(1'b0, 1100, n, found);
    check_eq("rerun_stb_clocks", n, 1024);
    check_eq("rerun_out", int'(pwm_out4), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
